// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } uart_rx_state_e;

  function automatic int calc_div(
    input int clk_hz,
    input int baud,
    input int os
  );
    int d;
    d = clk_hz / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: frame buffer between the receiver and its consumer.
import uart_pkg::*;

module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop frees the head slot, so a push while full still fits.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 3-sample majority vote per bit,
// with parity/framing/break/overrun detection and an output frame FIFO.
import uart_pkg::*;

module uart_rx_os #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 break_detect,
  output logic                 receiving
);

  localparam int DIV = calc_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int DCW = $clog2(DIV + 1);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam int FW  = DATA_BITS + 2;
  localparam parity_e PAR = parity_e'(2'(PARITY));

  uart_rx_state_e state_q, state_d;
  logic sync1_q, rxs_q, prev_q, armed_q, armed_d;
  logic [1:0] live_q;
  logic [DCW-1:0] div_q, div_d;
  logic [SCW-1:0] smp_q, smp_d;
  logic [BCW-1:0] bit_q, bit_d;
  logic stop_q, stop_d;
  logic s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic perr_q, perr_d, ferr_q, ferr_d;
  logic pvote_q, pvote_d, slow_q, slow_d;

  logic tick, bit_end, decide, vote, fall;
  logic fe_now, sl_now, exp_par;
  logic push, pop, full, empty;
  logic [FW-1:0] wdata, rdata;

  // rxs only counts as real once the reset values have flushed out.
  assign fall = armed_q & prev_q & ~rxs_q;

  assign tick    = (div_q == DCW'(DIV - 1));
  assign bit_end = tick && (smp_q == SCW'(OVERSAMPLE - 1));
  assign decide  = tick && (smp_q == SCW'(OVERSAMPLE / 2 + 1));
  assign vote    = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign fe_now  = ferr_q | ~vote;
  assign sl_now  = slow_q & ~vote;
  assign exp_par = (^sh_q) ^ (PAR == PAR_ODD);
  assign wdata   = {sh_q, perr_q, fe_now};
  assign armed_d = armed_q | (live_q[1] & rxs_q);

  always_comb begin
    state_d      = state_q;
    div_d        = div_q + 1'b1;
    smp_d        = smp_q;
    bit_d        = bit_q;
    stop_d       = stop_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    sh_d         = sh_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    pvote_d      = pvote_q;
    slow_d       = slow_q;
    push         = 1'b0;
    break_detect = 1'b0;
    if (tick) begin
      div_d = '0;
      smp_d = bit_end ? '0 : smp_q + 1'b1;
      if (smp_q == SCW'(OVERSAMPLE / 2 - 1)) s0_d = rxs_q;
      if (smp_q == SCW'(OVERSAMPLE / 2))     s1_d = rxs_q;
    end
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          div_d   = '0;
          smp_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          pvote_d = 1'b0;
          slow_d  = 1'b1;
        end
      end
      S_START: begin
        if (decide && vote) state_d = S_IDLE;
        else if (bit_end)   state_d = S_DATA;
      end
      S_DATA: begin
        if (decide) begin
          sh_d  = {vote, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
        end
        if (bit_end && bit_q == BCW'(DATA_BITS))
          state_d = (PAR == PAR_NONE) ? S_STOP : S_PARITY;
      end
      S_PARITY: begin
        if (decide) begin
          pvote_d = vote;
          perr_d  = (vote != exp_par);
        end
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          ferr_d = fe_now;
          slow_d = sl_now;
          stop_d = 1'b1;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // All-zero frame with every stop low is a break, not data.
            if (sh_q == '0 && !pvote_q && sl_now)
              break_detect = 1'b1;
            else
              push = 1'b1;
            state_d = vote ? S_IDLE : S_WAIT_IDLE;
            div_d   = '0;
            smp_d   = '0;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (!rxs_q) begin
          div_d = '0;
          smp_d = '0;
        end else if (bit_end) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      live_q  <= '0;
      armed_q <= 1'b0;
      div_q   <= '0;
      smp_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      sh_q    <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      pvote_q <= 1'b0;
      slow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx;
      rxs_q   <= sync1_q;
      prev_q  <= rxs_q;
      live_q  <= {live_q[0], 1'b1};
      armed_q <= armed_d;
      div_q   <= div_d;
      smp_q   <= smp_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      pvote_q <= pvote_d;
      slow_q  <= slow_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign valid         = !empty;
  assign pop           = valid && ready;
  assign overrun       = push && full && !pop;
  assign data          = valid ? rdata[FW-1:2] : '0;
  assign parity_error  = valid & rdata[1];
  assign framing_error = valid & rdata[0];
  assign receiving     = (state_q != S_IDLE);

endmodule
